work_window_seq: RTL and testbench
==================================

Name: work_window_seq

Overview:
- Parametrised working-window sequencer for the power/side-channel test top.
- Converts a one-cycle start strobe (from the local-bus data-ready path) into programmable activity windows that gate CH_NUM identical load instances.
- Generalises the fixed 6-cycle single-flag generator with programmable pre-delay, window length, burst repeat with inter-burst gap, per-channel enable, trigger output, abort and done.

Parameters:
- CH_NUM, 5: number of gated load channels (width of working_flag / ch_en).
- CNT_W, 8: width of delay/length/gap counters.
- REP_W, 4: width of burst repeat count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start strobe
- abort  in  1  synchronous abort, level-sensitive
- cfg_delay  in  CNT_W  cycles between start and first window
- cfg_len  in  CNT_W  window length in cycles; 0 treated as 1
- cfg_gap  in  CNT_W  idle cycles between bursts
- cfg_rep  in  REP_W  burst count; 0 treated as 1
- ch_en  in  CH_NUM  per-channel enable mask
- working_flag  out  CH_NUM  per-channel activity window
- trig_out  out  1  one-cycle pulse on the first active cycle of each burst
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after normal completion
- burst_idx  out  REP_W  index of the current burst, counting from 0

Behaviour:
- Reset is asynchronous on rst_n low: state IDLE; all outputs 0; counters and latched config 0.
- All outputs are registered.
- FSM states: IDLE, DELAY, ACTIVE, GAP.
- IDLE:
  - On start, latch all cfg_* and ch_en. Later cfg changes do not affect the running sequence.
  - Go to DELAY if cfg_delay>0, else to ACTIVE.
- Timing, with start sampled high at edge T:
  - working_flag is high on cycles T+1+D .. T+D+L, where D=cfg_delay and L=max(cfg_len,1).
  - D=0, L=6 reproduces the legacy 6-cycle window.
- DELAY: counts D cycles, then goes to ACTIVE.
- ACTIVE:
  - working_flag = ch_en_latched (replicated per bit); all flags 0 in other states.
  - trig_out pulses on the first ACTIVE cycle of each burst.
  - After L cycles: if bursts remain and cfg_gap>0, go to GAP. If bursts remain and cfg_gap=0, re-enter ACTIVE back-to-back; working_flag stays high and trig_out pulses again. If no bursts remain, go to IDLE.
- GAP: counts cfg_gap cycles with flags low, then enters ACTIVE and increments burst_idx.
- done: one-cycle pulse on the first IDLE cycle after the last ACTIVE cycle. burst_idx returns to 0 in the same cycle.
- start while busy is ignored (see the optional feature).
- abort:
  - When high, the next state is IDLE and flags drop on the following cycle.
  - No done pulse is generated; burst_idx is cleared.
  - abort has priority over start in the same cycle.
- ch_en_latched = 0: the sequence still runs (busy, trig_out, done) with all flags low.
- Counters run in CNT_W-bit arithmetic without wrap; the maximum window is 2^CNT_W-1 cycles.

Optional Feature:
- Macro: WORK_WINDOW_RETRIGGER_EN.
- Defined: start while busy (and abort low) re-latches config and restarts from DELAY/ACTIVE exactly as from IDLE. No done is issued for the interrupted sequence, burst_idx is reset, and trig_out pulses on the new first ACTIVE cycle.
- Undefined: start while busy is ignored.

Decomposition:
- Package work_window_pkg holds:
  - the state enum (IDLE, DELAY, ACTIVE, GAP);
  - default CNT_W/REP_W/CH_NUM localparams;
  - the legacy window constant 6.
- One sub-module, win_down_cnt: a loadable down-counter with a zero flag, instantiated once and shared across DELAY/ACTIVE/GAP by reloading it on each state entry.

Test Plan:
- Legacy: D=0, L=6, rep=1, ch_en=5'b11111, start at T -> flags 5'b11111 on T+1..T+6; trig_out at T+1; done at T+7; busy T+1..T+6.
- Delay and mask: D=3, L=4, ch_en=5'b00101 -> flags 5'b00101 on T+4..T+7 only; other bits never toggle.
- Bursts: D=0, L=2, gap=3, rep=3 -> active T+1..T+2, T+6..T+7, T+11..T+12; trig_out at T+1, T+6, T+11; burst_idx 0,1,2; done at T+13.
- Zero edges: L=0, rep=0, gap=0 with rep=2 -> single-cycle windows back-to-back on T+1 and T+2, flag continuous, two trig pulses.
- Abort at T+3 during L=6 -> flags low from T+4, busy low at T+4, no done. start while busy is ignored without the macro; with it, the sequence restarts and trig_out fires on the cycle after start.
- Reset asserted mid-ACTIVE -> all outputs 0 immediately (asynchronously); after release, the first start behaves as the legacy case.

Source files
------------

// File: rtl/work_window_pkg.sv
// Shared types and defaults for the working-window sequencer.
// Optional feature macro: WORK_WINDOW_RETRIGGER_EN (see work_window_seq).
package work_window_pkg;

    localparam int DEF_CH_NUM = 5;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_REP_W  = 4;
    localparam int LEGACY_LEN = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_GAP
    } state_t;

endpackage

// File: rtl/win_down_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared across DELAY/ACTIVE/GAP by reloading on each state entry.
module win_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/work_window_seq.sv
// Working-window sequencer: start strobe -> programmable gated bursts.
// Define WORK_WINDOW_RETRIGGER_EN to let start restart a running sequence.
module work_window_seq
    import work_window_pkg::*;
#(
    parameter int CH_NUM = DEF_CH_NUM,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_gap,
    input  logic [REP_W-1:0]  cfg_rep,
    input  logic [CH_NUM-1:0] ch_en,
    output logic [CH_NUM-1:0] working_flag,
    output logic              trig_out,
    output logic              busy,
    output logic              done,
    output logic [REP_W-1:0]  burst_idx
);

`ifdef WORK_WINDOW_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    state_t              r_state;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_gap;
    logic [REP_W-1:0]    r_rep;
    logic [CH_NUM-1:0]   r_ch_en;
    logic [CH_NUM-1:0]   r_flag;
    logic                r_trig;
    logic                r_busy;
    logic                r_done;
    logic [REP_W-1:0]    r_idx;

    state_t              w_nxt;
    logic                w_load;
    logic [CNT_W-1:0]    w_val;
    logic                w_dec;
    logic                w_zero;
    logic                w_trig;
    logic                w_done;
    logic                w_latch;
    logic [REP_W-1:0]    w_idx;
    logic [CNT_W-1:0]    w_len_in;
    logic [REP_W-1:0]    w_rep_in;
    logic [CH_NUM-1:0]   w_en;
    logic                w_more;
    logic                w_start_go;

    assign w_len_in   = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
    assign w_rep_in   = (cfg_rep == '0) ? REP_W'(1) : cfg_rep;
    assign w_en       = w_latch ? ch_en : r_ch_en;
    assign w_start_go = start && ((r_state == S_IDLE) || RETRIG);
    assign w_more     = ({1'b0, r_idx} + (REP_W+1)'(1)) < {1'b0, r_rep};

    win_down_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_val  (w_val),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    always_comb begin
        w_nxt   = r_state;
        w_load  = 1'b0;
        w_val   = '0;
        w_dec   = 1'b0;
        w_trig  = 1'b0;
        w_done  = 1'b0;
        w_latch = 1'b0;
        w_idx   = r_idx;
        if (abort) begin
            w_nxt = S_IDLE;
            w_idx = '0;
        end else if (w_start_go) begin
            w_latch = 1'b1;
            w_load  = 1'b1;
            w_idx   = '0;
            if (cfg_delay != '0) begin
                w_nxt = S_DELAY;
                w_val = cfg_delay - CNT_W'(1);
            end else begin
                w_nxt  = S_ACTIVE;
                w_val  = w_len_in - CNT_W'(1);
                w_trig = 1'b1;
            end
        end else begin
            unique case (r_state)
                S_IDLE: w_nxt = S_IDLE;
                S_DELAY: begin
                    if (w_zero) begin
                        w_nxt  = S_ACTIVE;
                        w_load = 1'b1;
                        w_val  = r_len - CNT_W'(1);
                        w_trig = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (!w_zero) begin
                        w_dec = 1'b1;
                    end else if (!w_more) begin
                        w_nxt  = S_IDLE;
                        w_done = 1'b1;
                        w_idx  = '0;
                    end else if (r_gap != '0) begin
                        w_nxt  = S_GAP;
                        w_load = 1'b1;
                        w_val  = r_gap - CNT_W'(1);
                    end else begin
                        // zero gap: next burst starts back-to-back
                        w_nxt  = S_ACTIVE;
                        w_load = 1'b1;
                        w_val  = r_len - CNT_W'(1);
                        w_trig = 1'b1;
                        w_idx  = r_idx + REP_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_zero) begin
                        w_nxt  = S_ACTIVE;
                        w_load = 1'b1;
                        w_val  = r_len - CNT_W'(1);
                        w_trig = 1'b1;
                        w_idx  = r_idx + REP_W'(1);
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_gap   <= '0;
            r_rep   <= '0;
            r_ch_en <= '0;
            r_flag  <= '0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_latch) begin
                r_len   <= w_len_in;
                r_gap   <= cfg_gap;
                r_rep   <= w_rep_in;
                r_ch_en <= ch_en;
            end
            r_flag <= (w_nxt == S_ACTIVE) ? w_en : '0;
            r_trig <= w_trig;
            r_busy <= (w_nxt != S_IDLE);
            r_done <= w_done;
            r_idx  <= w_idx;
        end
    end

    assign working_flag = r_flag;
    assign trig_out     = r_trig;
    assign busy         = r_busy;
    assign done         = r_done;
    assign burst_idx    = r_idx;

endmodule

// File: tb/tb_work_window_seq.sv
// Directed scoreboard bench for work_window_seq.
module tb_work_window_seq;
    import work_window_pkg::*;

    localparam int CH = 5;
    localparam int CW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_delay;
    logic [CW-1:0] cfg_len;
    logic [CW-1:0] cfg_gap;
    logic [RW-1:0] cfg_rep;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] working_flag;
    logic          trig_out;
    logic          busy;
    logic          done;
    logic [RW-1:0] burst_idx;

    typedef struct packed {
        logic [CH-1:0] flag;
        logic          trig;
        logic          busy;
        logic          done;
        logic [RW-1:0] idx;
    } obs_t;

    obs_t obs;
    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    assign obs = {working_flag, trig_out, busy, done, burst_idx};

    always #5 clk = ~clk;

    work_window_seq #(.CH_NUM(CH), .CNT_W(CW), .REP_W(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_delay    (cfg_delay),
        .cfg_len      (cfg_len),
        .cfg_gap      (cfg_gap),
        .cfg_rep      (cfg_rep),
        .ch_en        (ch_en),
        .working_flag (working_flag),
        .trig_out     (trig_out),
        .busy         (busy),
        .done         (done),
        .burst_idx    (burst_idx)
    );

    task automatic chk(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input logic [CH-1:0] f, input logic t,
                        input logic b, input logic d, input int i);
        obs_t e;
        e = {f, t, b, d, RW'(i)};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag);
        tick();
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            chk(tag, obs, q.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) cyc(tag);
    endtask

    // Expected outputs per cycle after start, built from the timing rules
    task automatic gen(input int d, input int l, input int g,
                       input int r, input logic [CH-1:0] en);
        int le, re;
        le = (l == 0) ? 1 : l;
        re = (r == 0) ? 1 : r;
        for (int k = 0; k < d; k++) push('0, 0, 1, 0, 0);
        for (int b = 0; b < re; b++) begin
            for (int k = 0; k < le; k++) push(en, k == 0, 1, 0, b);
            if (b < re - 1)
                for (int k = 0; k < g; k++) push('0, 0, 1, 0, b);
        end
        push('0, 0, 0, 1, 0);
        push('0, 0, 0, 0, 0);
    endtask

    task automatic go(input string tag, input int d, input int l,
                      input int g, input int r, input logic [CH-1:0] en);
        cfg_delay = CW'(d);
        cfg_len   = CW'(l);
        cfg_gap   = CW'(g);
        cfg_rep   = RW'(r);
        ch_en     = en;
        start     = 1'b1;
        gen(d, l, g, r, en);
        cyc(tag);
        start     = 1'b0;
        // running sequence must ignore these
        cfg_delay = 8'd9;
        cfg_len   = 8'd1;
        cfg_gap   = 8'd0;
        cfg_rep   = 4'd7;
        ch_en     = ~en;
        drain(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_delay = '0;
        cfg_len   = '0;
        cfg_gap   = '0;
        cfg_rep   = '0;
        ch_en     = '0;
        #12;
        chk("reset", obs, '0);
        rst_n = 1'b1;
        tick();

        go("legacy", 0, LEGACY_LEN, 0, 1, 5'b11111);
        go("delay_mask", 3, 4, 0, 1, 5'b00101);
        go("bursts", 0, 2, 3, 3, 5'b11111);
        go("len0_rep0", 0, 0, 0, 0, 5'b11010);
        go("b2b", 0, 0, 0, 2, 5'b11111);
        go("gap_b2b", 2, 3, 0, 2, 5'b01111);
        go("mask0", 1, 2, 1, 2, 5'b00000);

        // abort during the window at T+3
        cfg_delay = 0; cfg_len = 6; cfg_gap = 0; cfg_rep = 1;
        ch_en = 5'b11111;
        start = 1'b1;
        push(5'b11111, 1, 1, 0, 0);
        cyc("abort_a");
        start = 1'b0;
        push(5'b11111, 0, 1, 0, 0);
        push(5'b11111, 0, 1, 0, 0);
        cyc("abort_b");
        cyc("abort_c");
        abort = 1'b1;
        push('0, 0, 0, 0, 0);
        cyc("abort_drop");
        abort = 1'b0;
        push('0, 0, 0, 0, 0);
        cyc("abort_idle");

        // abort beats start in the same cycle
        start = 1'b1;
        abort = 1'b1;
        push('0, 0, 0, 0, 0);
        cyc("abort_prio");
        start = 1'b0;
        abort = 1'b0;
        push('0, 0, 0, 0, 0);
        cyc("abort_prio2");

        // start while busy
        cfg_len = 6;
        ch_en = 5'b11111;
        start = 1'b1;
        push(5'b11111, 1, 1, 0, 0);
        cyc("rt_a");
        start = 1'b0;
        push(5'b11111, 0, 1, 0, 0);
        cyc("rt_b");
        cfg_len = 2;
        ch_en = 5'b00011;
        start = 1'b1;
`ifdef WORK_WINDOW_RETRIGGER_EN
        push(5'b00011, 1, 1, 0, 0);
        push(5'b00011, 0, 1, 0, 0);
`else
        for (int k = 0; k < 4; k++) push(5'b11111, 0, 1, 0, 0);
`endif
        push('0, 0, 0, 1, 0);
        push('0, 0, 0, 0, 0);
        cyc("rt_c");
        start = 1'b0;
        drain("rt");

        // asynchronous reset mid-window
        cfg_len = 6;
        ch_en = 5'b11111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1 chk("rst_async", obs, '0);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_idle", obs, '0);
        go("legacy_post_rst", 0, LEGACY_LEN, 0, 1, 5'b11111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
